// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receive path, the receive FIFO and its consumer.
// The master modport drives frames and pops; the slave modport is the FIFO itself.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
);
    logic [7:0]  in_data;
    logic        in_valid;
    logic        rd_en;
    logic [6:0]  rd_data;
    logic        rd_err;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overflow;
    logic [7:0]  err_count;

    modport master (
        output in_data, in_valid, rd_en,
        input  rd_data, rd_err, empty, full, count, overflow, err_count
    );

    modport slave (
        input  in_data, in_valid, rd_en,
        output rd_data, rd_err, empty, full, count, overflow, err_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Captures UART frames on the rising edge of in_valid, checks parity and buffers
// the 7-bit character plus error flag in a first-word-fall-through FIFO.
module uart_rx_fifo #(
    parameter int DEPTH      = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_inValidQ;
    logic          r_overflow;
    logic [7:0]    r_errCount;

    logic w_frameEvt;
    logic w_perr;
    logic w_empty;
    logic w_full;
    logic w_wr;
    logic w_rd;

    assign w_frameEvt = bus.in_valid & ~r_inValidQ;
    assign w_perr     = (^bus.in_data) ^ PARITY_ODD;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    // A pop on a full FIFO frees the slot the incoming frame needs in the same cycle.
    assign w_wr       = w_frameEvt & (~w_full | bus.rd_en);
    assign w_rd       = bus.rd_en & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrPtr] <= {w_perr, bus.in_data[6:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_inValidQ <= 1'b0;
            r_overflow <= 1'b0;
            r_errCount <= '0;
        end else begin
            r_inValidQ <= bus.in_valid;
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rd) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_frameEvt & w_full & ~bus.rd_en) begin
                r_overflow <= 1'b1;
            end
            // Dropped frames still count toward the error total.
            if (w_frameEvt & w_perr & (r_errCount != 8'hFF)) begin
                r_errCount <= r_errCount + 1'b1;
            end
        end
    end

    assign bus.rd_data   = r_mem[r_rdPtr][6:0];
    assign bus.rd_err    = r_mem[r_rdPtr][7];
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.err_count = r_errCount;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART core. It captures each 8-bit frame the UART presents on its `data_out`/`out_valid` outputs and checks the parity bit. The 7-bit character is stored with a per-entry parity-error flag in a first-word-fall-through FIFO, and a consumer drains it with a simple read strobe. It also keeps a sticky overflow flag and a saturating parity-error counter for status readout.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥ 2. `AW = $clog2(DEPTH)`.
- `PARITY_ODD`, default 0: 0 = even parity (XOR of all 8 frame bits is 0 when good); 1 = odd parity (XOR is 1 when good).

Ports:
- `clk` — input, 1 — system clock; all state updates on the rising edge.
- `rst` — input, 1 — reset. One clock; reset is asynchronous and active-high.
- `in_data` — input, 8 — frame from the UART `data_out`. `[6:0]` is the character; `[7]` is the parity bit.
- `in_valid` — input, 1 — UART `out_valid`. May stay high for any number of cycles per frame.
- `rd_en` — input, 1 — consumer pop strobe; one entry is popped per cycle it is high while `!empty`.
- `rd_data` — output, 7 — character at the FIFO head; valid whenever `!empty`.
- `rd_err` — output, 1 — parity-error flag of the head entry; valid whenever `!empty`.
- `empty` — output, 1 — FIFO holds 0 entries.
- `full` — output, 1 — FIFO holds `DEPTH` entries.
- `count` — output, AW+1 — current occupancy, 0..DEPTH.
- `overflow` — output, 1 — sticky; set when a frame is dropped because the FIFO is full. Cleared only by `rst`.
- `err_count` — output, 8 — saturating count of frames detected with bad parity.

## Operation

- **Frame detect:** `in_valid` is registered into `in_valid_q`. A frame event occurs on the cycle where `in_valid & ~in_valid_q`. Exactly one event is produced per rising edge of `in_valid`, however long it stays high.
- **Parity check:** on each frame event, `perr = (^in_data) ^ PARITY_ODD`. `perr = 1` means the parity is bad.
- **Write:** on a frame event with `!full`, or with `full & rd_en` in the same cycle, store `{perr, in_data[6:0]}` at `wr_ptr` and advance `wr_ptr`.
- **Dropped frame:** on a frame event with `full & !rd_en`, the frame is discarded and `overflow` is set to 1.
- **Error counter:** `err_count` increments on every frame event with `perr = 1`, whether the frame is stored or dropped. It holds at 255.
- **Read:** on `rd_en & !empty`, advance `rd_ptr`. `rd_en` while `empty` is ignored and causes no pointer change or error.
- **Pointers:** `wr_ptr` and `rd_ptr` are AW bits wide and wrap modulo DEPTH.
- **Occupancy:** `count` is the registered occupancy. `empty = (count == 0)` and `full = (count == DEPTH)`.
- **Read and write in the same cycle:**
  - `!empty & !full`: both happen; `count` is unchanged.
  - `full`: both happen; `count` stays at DEPTH; no overflow.
  - `empty`: the write is accepted and the read is ignored; `count` becomes 1.
- **Head outputs:** `rd_data` and `rd_err` are driven combinationally from `mem[rd_ptr]` (first-word fall-through).
- **Reset:** asserting `rst` at any time, including mid-frame with `in_valid` held high, clears:
  - `wr_ptr`, `rd_ptr`, `count`, `in_valid_q`, `overflow`, `err_count` → 0;
  - `empty` → 1, `full` → 0.

  Memory contents are not cleared. If `in_valid` is still high when `rst` deasserts, this produces a fresh frame event on the first active cycle.

## Timing

- **Reset values:**
  - `empty` = 1; `full` = 0; `count` = 0; `overflow` = 0; `err_count` = 0.
  - `rd_data` and `rd_err` are don't-care while `empty`.
- **Write latency:** `in_valid` is first sampled high at edge N. `empty` falls and `rd_data`/`rd_err` are valid after edge N, i.e. one cycle.
- **Read latency:** with `rd_en` sampled high at edge M, the next entry (or `empty = 1`) is visible after edge M.
- **Status timing:** `overflow` and `err_count` update at the same edge as the frame event.
- **Throughput:** one write and one read per cycle. Back-to-back frames need `in_valid` to drop for at least one cycle between them.

## Test plan

1. **Single good frame.** Reset, then pulse `in_valid` for 2 cycles with `in_data = 8'hED` (char 7'b1101101, even parity).
   → One cycle later: `empty = 0`, `count = 1`, `rd_data = 7'h6D`, `rd_err = 0`. `err_count` stays 0. No second entry appears despite the 2-cycle pulse.
2. **Bad parity.** Send `8'h6D`, then `8'hAA`.
   → Entries are `{1, 7'h6D}` then `{0, 7'h2A}`; `err_count = 1`. Popping twice yields those values in order, then `empty = 1`.
3. **Fill and overflow** (DEPTH = 4). Send 5 good frames (8'h81, 8'h82, 8'h84, 8'h88, 8'h90) with no reads.
   → After the 4th: `full = 1`, `count = 4`. The 5th is dropped and `overflow = 1`. Popping all four returns 7'h01, 7'h02, 7'h04, 7'h08.
4. **Simultaneous events.**
   - With the FIFO full, assert a frame edge and `rd_en` in the same cycle → `count` stays 4, `overflow` stays 0, and the new data lands last.
   - With the FIFO empty, assert a frame edge and `rd_en` together → `count = 1`.
5. **Wrap and saturation.** Stream 300 bad-parity frames with concurrent reads.
   → Pointers wrap with no data loss; `err_count` stops at 255.
6. **Reset mid-operation.** Hold `in_valid` high with 3 entries stored, then pulse `rst`.
   → All outputs return to reset values. After `rst` deasserts, exactly one new entry is captured from the still-high `in_valid`.
